spi_master: RTL and testbench

- Byte-oriented SPI initiator for the FSM processor.
- Drives sck/mosi/ss_n to the SPI peripheral modules (counters etc.) and captures miso.
- Peripherals gate their internal clock as (!ss & sck), sample mosi on sck rising, update miso on sck rising, and expect exactly 8 rising edges per selected frame. This block guarantees all of these.
- Processor side is a start/busy/done handshake.

---
 rtl/spi_master_pkg.sv | 34 +++
 rtl/spi_master_if.sv | 40 ++++
 rtl/spi_clk_div.sv | 49 ++++
 rtl/spi_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_master.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg : shared definitions for the byte-oriented SPI initiator.
//
// Contents
//   SPI_BYTE_W          : bits per SPI frame (8)
//   SPI_CLK_DIV_DEFAULT : default clk cycles per sck half-period
//   SPI_DIV_W           : width of the half-period counter (CLK_DIV <= 255)
//   spi_state_e         : FSM state encoding
//
// Build option
//   SPI_MASTER_BURST_EN : adds the HELD state (select kept low between
//                         bytes) and SWITCH (select release gap when the
//                         burst moves to another peripheral).
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_BYTE_W          = 8;
    localparam int SPI_CLK_DIV_DEFAULT = 4;
    localparam int SPI_DIV_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
`ifdef SPI_MASTER_BURST_EN
        ST_TAIL,
        ST_HELD,
        ST_SWITCH
`else
        ST_TAIL
`endif
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if : processor-side start/busy/done handshake of spi_master.
//
// Signals
//   start   : request a byte transfer (taken only while busy = 0)
//   tx_data : byte to send, latched on acceptance
//   ss_sel  : target peripheral index, latched on acceptance
//   hold    : (SPI_MASTER_BURST_EN only) keep the select low after this byte
//   busy    : transfer in progress
//   done    : one-cycle end-of-transfer pulse
//   rx_data : received byte, valid from done until the next done
//
// Modports
//   master : the requester (processor / bench)
//   slave  : the spi_master block itself
// -----------------------------------------------------------------------------
interface spi_master_if #(
    parameter int SS_W = 2
) ();
    import spi_pkg::*;

    logic                  start;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic [SS_W-1:0]       ss_sel;
`ifdef SPI_MASTER_BURST_EN
    logic                  hold;
`endif
    logic                  busy;
    logic                  done;
    logic [SPI_BYTE_W-1:0] rx_data;

`ifdef SPI_MASTER_BURST_EN
    modport master (output start, tx_data, ss_sel, hold, input busy, done, rx_data);
    modport slave  (input start, tx_data, ss_sel, hold, output busy, done, rx_data);
`else
    modport master (output start, tx_data, ss_sel, input busy, done, rx_data);
    modport slave  (input start, tx_data, ss_sel, output busy, done, rx_data);
`endif

endinterface

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div : loadable half-period counter for spi_master.
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset (counter cleared)
//   load      : restart the phase; asserted on every FSM state change
//   phase_end : high during the last clk cycle of the current phase
//
// After a load the counter holds DIV-1 and counts down; phase_end is the
// zero count, so each phase lasts exactly DIV cycles (DIV = 1 gives a
// permanently asserted phase_end).
// -----------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic phase_end
);

    localparam logic [SPI_DIV_W-1:0] RELOAD = SPI_DIV_W'(DIV - 1);

    logic [SPI_DIV_W-1:0] cnt_reg;
    logic [SPI_DIV_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = RELOAD;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign phase_end = (cnt_reg == '0);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master : byte-oriented SPI initiator (mode 0, sck idles low).
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : spi_master_if.slave handshake (start/tx_data/ss_sel in,
//            busy/done/rx_data out)
//   sck    : SPI clock, idles low, CLK_DIV clk cycles per half-period
//   mosi   : serial data out, MSB first, changes only on sck falling edges
//            or at acceptance
//   miso   : serial data in, LSB first, already synchronous to clk
//   ss_n   : active-low selects, at most one low, change only while sck = 0
//
// Parameters
//   CLK_DIV : clk cycles per sck half-period (1..255)
//   SS_W    : width of ss_sel; 2**SS_W select lines
//
// Build option
//   SPI_MASTER_BURST_EN : adds bus.hold and the HELD/SWITCH states so a
//                         select can stay low across several bytes.
//
// Frame timing from the acceptance edge T0: sck rises at T0+CLK_DIV*(2k+1)
// for k = 0..7, and done / select release happen at T0+17*CLK_DIV.
// All SPI pins are registered so peripherals that gate their clock with
// (!ss & sck) never see glitches.
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter  int CLK_DIV = SPI_CLK_DIV_DEFAULT,
    parameter  int SS_W    = 2,
    localparam int NUM_SS  = 2 ** SS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_if.slave       bus,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    spi_state_e            state_reg,    state_next;
    logic [2:0]            bit_idx_reg,  bit_idx_next;
    logic [SPI_BYTE_W-1:0] tx_shift_reg, tx_shift_next;
    logic [SPI_BYTE_W-1:0] rx_shift_reg, rx_shift_next;
    logic [SPI_BYTE_W-1:0] rx_data_reg,  rx_data_next;
    logic [SS_W-1:0]       sel_reg,      sel_next;
    logic                  sck_reg,      sck_next;
    logic                  mosi_reg,     mosi_next;
    logic                  busy_reg,     busy_next;
    logic                  done_reg,     done_next;
    logic [NUM_SS-1:0]     ss_n_reg,     ss_n_next;
`ifdef SPI_MASTER_BURST_EN
    logic                  hold_reg,     hold_next;
    logic [NUM_SS-1:0]     cur_sel_n;
`endif

    logic [NUM_SS-1:0] req_sel_n;
    logic              phase_end;
    logic              div_load;

    // Active-low one-hot decode of the requested select
    genvar gi;
    for (gi = 0; gi < NUM_SS; gi++) begin : g_req_dec
        assign req_sel_n[gi] = (bus.ss_sel != SS_W'(gi));
    end

`ifdef SPI_MASTER_BURST_EN
    // Decode of the latched select, used when SWITCH re-asserts it
    for (gi = 0; gi < NUM_SS; gi++) begin : g_cur_dec
        assign cur_sel_n[gi] = (sel_reg != SS_W'(gi));
    end
`endif

    // Every state entry starts a fresh CLK_DIV-cycle phase
    assign div_load = (state_next != state_reg);

    spi_clk_div #(
        .DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .phase_end (phase_end)
    );

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            bit_idx_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            sel_reg      <= '0;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ss_n_reg     <= '1;
`ifdef SPI_MASTER_BURST_EN
            hold_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            bit_idx_reg  <= bit_idx_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            sel_reg      <= sel_next;
            sck_reg      <= sck_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            ss_n_reg     <= ss_n_next;
`ifdef SPI_MASTER_BURST_EN
            hold_reg     <= hold_next;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (phase_end) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_end) state_next = (bit_idx_reg == 3'd7) ? ST_TAIL : ST_LOW;
            end
            ST_TAIL: begin
`ifdef SPI_MASTER_BURST_EN
                if (phase_end) state_next = hold_reg ? ST_HELD : ST_IDLE;
`else
                if (phase_end) state_next = ST_IDLE;
`endif
            end
`ifdef SPI_MASTER_BURST_EN
            ST_HELD: begin
                if (bus.start) begin
                    state_next = (bus.ss_sel == sel_reg) ? ST_LOW : ST_SWITCH;
                end else if (!bus.hold) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                if (phase_end) state_next = ST_LOW;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        bit_idx_next  = bit_idx_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        sel_next      = sel_reg;
        sck_next      = sck_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        ss_n_next     = ss_n_reg;
`ifdef SPI_MASTER_BURST_EN
        hold_next     = hold_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    tx_shift_next = bus.tx_data;
                    mosi_next     = bus.tx_data[SPI_BYTE_W-1];
                    sel_next      = bus.ss_sel;
                    bit_idx_next  = '0;
                    busy_next     = 1'b1;
                    ss_n_next     = req_sel_n;
`ifdef SPI_MASTER_BURST_EN
                    hold_next     = bus.hold;
`endif
                end
            end
            ST_LOW: begin
                // miso is sampled in the last low cycle, i.e. just before
                // the rising edge the peripheral uses to advance it
                if (phase_end) begin
                    rx_shift_next[bit_idx_reg] = miso;
                    sck_next = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    sck_next = 1'b0;
                    if (bit_idx_reg != 3'd7) begin
                        bit_idx_next  = bit_idx_reg + 3'd1;
                        mosi_next     = tx_shift_reg[SPI_BYTE_W-2];
                        tx_shift_next = {tx_shift_reg[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
            ST_TAIL: begin
                // The extra low phase keeps the select asserted for a full
                // half-period after the last falling edge
                if (phase_end) begin
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    rx_data_next = rx_shift_reg;
                    ss_n_next    = '1;
`ifdef SPI_MASTER_BURST_EN
                    if (hold_reg) ss_n_next = ss_n_reg;
`endif
                end
            end
`ifdef SPI_MASTER_BURST_EN
            ST_HELD: begin
                if (bus.start) begin
                    tx_shift_next = bus.tx_data;
                    mosi_next     = bus.tx_data[SPI_BYTE_W-1];
                    sel_next      = bus.ss_sel;
                    bit_idx_next  = '0;
                    busy_next     = 1'b1;
                    hold_next     = bus.hold;
                    // Moving to another peripheral: drop the old select
                    // first, SWITCH asserts the new one after CLK_DIV cycles
                    if (bus.ss_sel != sel_reg) ss_n_next = '1;
                end else if (!bus.hold) begin
                    ss_n_next = '1;
                end
            end
            ST_SWITCH: begin
                if (phase_end) ss_n_next = cur_sel_n;
            end
`endif
            default: ;
        endcase
    end

    assign sck         = sck_reg;
    assign mosi        = mosi_reg;
    assign ss_n        = ss_n_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master : self-checking bench for spi_master.
//
// Two instances: dut_a (CLK_DIV = 4) with miso either looped back from mosi
// or driven by a small counter peripheral on select 1, and dut_b
// (CLK_DIV = 1) in loopback. A frame-level model predicts every output on
// every cycle from the transfer timing (cycle offset from acceptance), and
// directed tests pin the model with literal latencies and received bytes.
// With SPI_MASTER_BURST_EN defined a two-byte held-select burst is added.
// -----------------------------------------------------------------------------
module tb_spi_master;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // stimulus
    logic       start_r [2];
    logic [7:0] tx_r    [2];
    logic [1:0] sel_r   [2];
    logic       loop_a;
`ifdef SPI_MASTER_BURST_EN
    logic       hold_r;
`endif

    // observed pins
    logic       sck_w  [2];
    logic       mosi_w [2];
    logic       miso_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [7:0] rx_w   [2];
    logic [3:0] ss_n_w [2];

    spi_master_if #(.SS_W(2)) bus_a ();
    spi_master_if #(.SS_W(2)) bus_b ();

    assign bus_a.start   = start_r[0];
    assign bus_a.tx_data = tx_r[0];
    assign bus_a.ss_sel  = sel_r[0];
    assign bus_b.start   = start_r[1];
    assign bus_b.tx_data = tx_r[1];
    assign bus_b.ss_sel  = sel_r[1];
`ifdef SPI_MASTER_BURST_EN
    assign bus_a.hold    = hold_r;
    assign bus_b.hold    = 1'b0;
`endif
    assign busy_w[0] = bus_a.busy;
    assign done_w[0] = bus_a.done;
    assign rx_w[0]   = bus_a.rx_data;
    assign busy_w[1] = bus_b.busy;
    assign done_w[1] = bus_b.done;
    assign rx_w[1]   = bus_b.rx_data;

    spi_master #(.CLK_DIV(4), .SS_W(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a),
        .sck (sck_w[0]), .mosi (mosi_w[0]), .miso (miso_w[0]), .ss_n (ss_n_w[0])
    );

    spi_master #(.CLK_DIV(1), .SS_W(2)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b),
        .sck (sck_w[1]), .mosi (mosi_w[1]), .miso (miso_w[1]), .ss_n (ss_n_w[1])
    );

    // Counter peripheral on dut_a select 1: gated clock, shifts mosi in on
    // rising edges, shifts its output register (LSB first) on rising edges.
    // After 8 bits: 0x05 clears, 0x04 increments, anything else reads; the
    // output register is then reloaded with the count.
    logic       pclk;
    logic [7:0] p_in    = 8'h00;
    logic [7:0] p_out   = 8'h00;
    logic [7:0] p_count = 8'h00;
    int         p_bits  = 0;
    assign pclk = !ss_n_w[0][1] && sck_w[0];
    always @(posedge pclk) begin
        p_in <= {p_in[6:0], mosi_w[0]};
        if (p_bits == 7) begin
            p_bits <= 0;
            case ({p_in[6:0], mosi_w[0]})
                8'h05: begin p_count <= 8'h00; p_out <= 8'h00; end
                8'h04: begin p_count <= p_count + 8'd1; p_out <= p_count + 8'd1; end
                default: p_out <= p_count;
            endcase
        end else begin
            p_bits <= p_bits + 1;
            p_out  <= p_out >> 1;
        end
    end

    assign miso_w[0] = loop_a ? mosi_w[0] : p_out[0];
    assign miso_w[1] = mosi_w[1];

    // ---------------- frame model ----------------
    int         div_m    [2] = '{4, 1};
    int         n_m      [2] = '{-1, -1};   // cycles since acceptance, -1 idle
    logic [7:0] tx_m     [2];
    logic [7:0] rx_acc   [2];
    logic [7:0] rx_exp   [2] = '{8'h00, 8'h00};
    int         sel_m    [2];
    bit         model_en [2] = '{1'b1, 1'b1};
    int         sck_rise [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    logic       sck_prev [2] = '{1'b0, 1'b0};

    function automatic string tag(input int d, input string f);
        return $sformatf("dut%0d_%s_cyc%0d", d, f, cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    initial begin : compare
        int dv;
        int n;
        int k;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (sck_w[d] && !sck_prev[d]) sck_rise[d]++;
                sck_prev[d] = sck_w[d];
                if (done_w[d]) done_cnt[d]++;
                if (model_en[d]) begin
                    if (!rst_n) begin
                        n_m[d]    = -1;
                        rx_exp[d] = 8'h00;
                    end
                    dv = div_m[d];
                    n  = n_m[d];
                    if (n < 0 || n == 17 * dv) begin
                        chk(tag(d, "ss_n"), 32'(ss_n_w[d]), 32'hF);
                        chk(tag(d, "sck"),  32'(sck_w[d]),  32'h0);
                        chk(tag(d, "busy"), 32'(busy_w[d]), 32'h0);
                        chk(tag(d, "done"), 32'(done_w[d]), (n == 17 * dv) ? 32'h1 : 32'h0);
                        chk(tag(d, "rx"),   32'(rx_w[d]),   32'(rx_exp[d]));
                    end else begin
                        k = n / (2 * dv);
                        if (k > 7) k = 7;
                        chk(tag(d, "ss_n"), 32'(ss_n_w[d]), 32'(4'(~(4'b0001 << sel_m[d]))));
                        chk(tag(d, "sck"),  32'(sck_w[d]),
                            (((n / dv) % 2 == 1) && (n < 16 * dv)) ? 32'h1 : 32'h0);
                        chk(tag(d, "mosi"), 32'(mosi_w[d]), 32'(tx_m[d][7-k]));
                        chk(tag(d, "busy"), 32'(busy_w[d]), 32'h1);
                        chk(tag(d, "done"), 32'(done_w[d]), 32'h0);
                        chk(tag(d, "rx"),   32'(rx_w[d]),   32'(rx_exp[d]));
                    end
                    // predict the state after the coming edge
                    if (rst_n) begin
                        if (n < 0 || n == 17 * dv) begin
                            if (start_r[d]) begin
                                n_m[d]   = 0;
                                tx_m[d]  = tx_r[d];
                                sel_m[d] = int'(sel_r[d]);
                            end else begin
                                n_m[d] = -1;
                            end
                        end else begin
                            n_m[d] = n + 1;
                            if (n_m[d] < 16 * dv && n_m[d] % (2 * dv) == dv)
                                rx_acc[d][(n_m[d] - dv) / (2 * dv)] = miso_w[d];
                            if (n_m[d] == 17 * dv) rx_exp[d] = rx_acc[d];
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int d, input logic [7:0] b, input int s, output int t0);
        @(posedge clk); #1;
        start_r[d] = 1'b1;
        tx_r[d]    = b;
        sel_r[d]   = 2'(s);
        @(posedge clk); #1;
        start_r[d] = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int d, input int t0, output int lat,
                             output logic [7:0] rx, output bit released);
        lat = -1;
        rx = 8'h00;
        released = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_w[d]) begin
                lat = cyc - t0;
                rx  = rx_w[d];
                break;
            end
            if (ss_n_w[d] == 4'hF) released = 1'b1;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_done_timeout: got no done, required one within 300 cycles", d);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, required finish before 400000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0, lat, r0, dc;
        logic [7:0] rx;
        bit rel;
        logic [7:0] cmds [5];
        cmds = '{8'h05, 8'h04, 8'h04, 8'h04, 8'h00};
        for (int d = 0; d < 2; d++) begin
            start_r[d] = 1'b0;
            tx_r[d]    = 8'h00;
            sel_r[d]   = 2'd0;
        end
        loop_a = 1'b1;
`ifdef SPI_MASTER_BURST_EN
        hold_r = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ss_n_dut%0d", d), 32'(ss_n_w[d]), 32'hF);
            chk($sformatf("reset_sck_dut%0d", d),  32'(sck_w[d]),  32'h0);
            chk($sformatf("reset_mosi_dut%0d", d), 32'(mosi_w[d]), 32'h0);
            chk($sformatf("reset_busy_dut%0d", d), 32'(busy_w[d]), 32'h0);
            chk($sformatf("reset_done_dut%0d", d), 32'(done_w[d]), 32'h0);
            chk($sformatf("reset_rx_dut%0d", d),   32'(rx_w[d]),   32'h00);
        end
        rst_n = 1'b1;

        // loopback A0 at CLK_DIV 4
        r0 = sck_rise[0];
        send(0, 8'hA0, 0, t0);
        wait_done(0, t0, lat, rx, rel);
        chk("loop_a0_latency", 32'(lat), 32'd68);
        chk("loop_a0_rx", 32'(rx), 32'h05);
        chk("loop_a0_sck_rises", 32'(sck_rise[0] - r0), 32'd8);
        chk("loop_a0_no_release", 32'(rel), 32'h0);

        // CLK_DIV 1, select 2
        r0 = sck_rise[1];
        send(1, 8'h3C, 2, t0);
        @(negedge clk);
        chk("div1_ss_n_sel2", 32'(ss_n_w[1]), 32'hB);
        wait_done(1, t0, lat, rx, rel);
        chk("div1_latency", 32'(lat), 32'd17);
        chk("div1_rx", 32'(rx), 32'h3C);
        chk("div1_ss_n_after", 32'(ss_n_w[1]), 32'hF);
        chk("div1_sck_rises", 32'(sck_rise[1] - r0), 32'd8);

        // counter peripheral on select 1
        loop_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(0, cmds[i], 1, t0);
            wait_done(0, t0, lat, rx, rel);
        end
        chk("counter_read_rx", 32'(rx), 32'h03);
        loop_a = 1'b1;

        // start while busy is ignored
        dc = done_cnt[0];
        send(0, 8'hC1, 0, t0);
        repeat (10) @(posedge clk);
        #1;
        start_r[0] = 1'b1;
        tx_r[0]    = 8'h5A;
        sel_r[0]   = 2'd3;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        wait_done(0, t0, lat, rx, rel);
        chk("busy_ignore_latency", 32'(lat), 32'd68);
        chk("busy_ignore_rx", 32'(rx), 32'h83);
        repeat (40) @(negedge clk);
        chk("busy_ignore_done_count", 32'(done_cnt[0] - dc), 32'd1);

        // asynchronous reset mid-transfer
        send(0, 8'hFF, 0, t0);
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", 32'(busy_w[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ss_n", 32'(ss_n_w[0]), 32'hF);
        chk("rst_mid_sck", 32'(sck_w[0]), 32'h0);
        chk("rst_mid_busy", 32'(busy_w[0]), 32'h0);
        chk("rst_mid_rx", 32'(rx_w[0]), 32'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, 8'hA0, 0, t0);
        wait_done(0, t0, lat, rx, rel);
        chk("after_rst_latency", 32'(lat), 32'd68);
        chk("after_rst_rx", 32'(rx), 32'h05);

`ifdef SPI_MASTER_BURST_EN
        // two-byte held burst on select 1
        model_en[0] = 1'b0;
        r0 = sck_rise[0];
        hold_r = 1'b1;
        send(0, 8'hA0, 1, t0);
        wait_done(0, t0, lat, rx, rel);
        chk("burst1_rx", 32'(rx), 32'h05);
        chk("burst1_no_release", 32'(rel), 32'h0);
        chk("burst1_ss_n_held", 32'(ss_n_w[0]), 32'hD);
        chk("burst1_busy", 32'(busy_w[0]), 32'h0);
        @(posedge clk); #1;
        start_r[0] = 1'b1;
        tx_r[0]    = 8'h3C;
        sel_r[0]   = 2'd1;
        hold_r     = 1'b0;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        t0 = cyc;
        wait_done(0, t0, lat, rx, rel);
        chk("burst2_latency", 32'(lat), 32'd68);
        chk("burst2_rx", 32'(rx), 32'h3C);
        chk("burst2_no_release", 32'(rel), 32'h0);
        chk("burst2_ss_n_released", 32'(ss_n_w[0]), 32'hF);
        chk("burst_sck_rises", 32'(sck_rise[0] - r0), 32'd16);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
